// File: rtl/operand_fetch.sv
// Operand fetch: register-file read addressing, writeback bypass, pending-write
// scoreboard with RAW/WAW stall, and a registered operand stage for execute.
// Define OPFETCH_BYPASS_EN to forward same-cycle writeback data and release hazards in that cycle.
module operand_fetch #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic             in_rd_we,
  input  logic [TAG_W-1:0] in_tag,
  output logic [4:0]       rf_rs1,
  output logic [4:0]       rf_rs2,
  input  logic [XLEN-1:0]  rf_rd1,
  input  logic [XLEN-1:0]  rf_rd2,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_wd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_op1,
  output logic [XLEN-1:0]  out_op2,
  output logic [4:0]       out_rd,
  output logic             out_rd_we,
  output logic [TAG_W-1:0] out_tag
);

  // Handshake: a transfer happens on a cycle where valid && ready at the rising
  // edge; ready never looks at valid, and a producer holds its payload until taken.

  logic [31:0]      pend_q, pend_d;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  op1_q, op1_d, op2_q, op2_d;
  logic [4:0]       rd_q, rd_d;
  logic             rd_we_q, rd_we_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic            eff_we, clr;
  logic            byp1, byp2, bypd;
  logic            hz1, hz2, hzd, stall;
  logic            ready_c, accept;
  logic [XLEN-1:0] op1_sel, op2_sel;

  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;

  always_comb begin
    eff_we = in_rd_we && (in_rd != 5'd0);
    clr    = wb_we && (wb_rd != 5'd0);
`ifdef OPFETCH_BYPASS_EN
    byp1 = clr && (wb_rd == in_rs1);
    byp2 = clr && (wb_rd == in_rs2);
    bypd = clr && (wb_rd == in_rd);
`else
    byp1 = 1'b0;
    byp2 = 1'b0;
    bypd = 1'b0;
`endif
    // A hazard on a register being written back this cycle resolves only with bypass.
    hz1   = (in_rs1 != 5'd0) && pend_q[in_rs1] && !byp1;
    hz2   = (in_rs2 != 5'd0) && pend_q[in_rs2] && !byp2;
    hzd   = eff_we && pend_q[in_rd] && !bypd;
    stall = hz1 || hz2 || hzd;

    ready_c = (!out_valid_q || out_ready) && !stall;
    accept  = in_valid && ready_c;

    if (in_rs1 == 5'd0) op1_sel = '0;
    else if (byp1)      op1_sel = wb_wd;
    else                op1_sel = rf_rd1;

    if (in_rs2 == 5'd0) op2_sel = '0;
    else if (byp2)      op2_sel = wb_wd;
    else                op2_sel = rf_rd2;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    tag_d       = tag_q;
    if (accept) begin
      out_valid_d = 1'b1;
      op1_d       = op1_sel;
      op2_d       = op2_sel;
      rd_d        = in_rd;
      rd_we_d     = eff_we;
      tag_d       = in_tag;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear before set so a same-cycle clear and re-issue leaves the bit pending.
  always_comb begin
    pend_d = pend_q;
    if (clr)              pend_d[wb_rd] = 1'b0;
    if (accept && eff_we) pend_d[in_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
      tag_q       <= '0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      tag_q       <= tag_d;
    end
  end

  assign in_ready  = ready_c;
  assign out_valid = out_valid_q;
  assign out_op1   = op1_q;
  assign out_op2   = op2_q;
  assign out_rd    = rd_q;
  assign out_rd_we = rd_we_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vectors against a cycle model of the
// scoreboard/handshake rules, plus literal pins at key points.
module tb_operand_fetch;
  localparam int XLEN  = 32;
  localparam int TAG_W = 32;
`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [4:0]       in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic             in_rd_we = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [4:0]       rf_rs1, rf_rs2;
  logic [XLEN-1:0]  rf_rd1, rf_rd2;
  logic             wb_we = 1'b0;
  logic [4:0]       wb_rd = '0;
  logic [XLEN-1:0]  wb_wd = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  out_op1, out_op2;
  logic [4:0]       out_rd;
  logic             out_rd_we;
  logic [TAG_W-1:0] out_tag;
  logic             force_ones = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  operand_fetch #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we), .in_tag(in_tag),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_tag(out_tag)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- register file model ----------------
  logic [XLEN-1:0] regs [32];

  function automatic logic [XLEN-1:0] init_val(int i);
    if (i == 3) return 32'h11;
    if (i == 4) return 32'h22;
    return 32'h1000 + 32'(i);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
    end else if (wb_we && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_wd;
    end
  end

  assign rf_rd1 = force_ones ? '1 : ((rf_rs1 == 5'd0) ? '0 : regs[rf_rs1]);
  assign rf_rd2 = force_ones ? '1 : ((rf_rs2 == 5'd0) ? '0 : regs[rf_rs2]);

  // ---------------- behavioural model ----------------
  bit              m_pend [32];
  bit              m_valid;
  logic [XLEN-1:0] m_op1, m_op2;
  logic [4:0]      m_rd;
  bit              m_rd_we;
  logic [TAG_W-1:0] m_tag;

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // Register still owed a write, unless this cycle's writeback releases it.
  function automatic bit owed(logic [4:0] r);
    return (r != 5'd0) && m_pend[r] && !(BYP && wb_we && wb_rd == r);
  endfunction

  function automatic logic [XLEN-1:0] operand(logic [4:0] r);
    if (r == 5'd0) return '0;
    if (BYP && wb_we && wb_rd == r) return wb_wd;
    return regs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_rd_we = 1'b0; m_tag = '0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare at the negedge, advance the model, return at posedge+1.
  task automatic step();
    bit stall, exp_ready, acc;
    @(negedge clk);
    stall     = owed(in_rs1) || owed(in_rs2) || (in_rd_we && owed(in_rd));
    exp_ready = (!m_valid || out_ready) && !stall;
    acc       = in_valid && exp_ready;
    chk("in_ready",  64'(in_ready),  64'(exp_ready));
    chk("rf_rs1",    64'(rf_rs1),    64'(in_rs1));
    chk("rf_rs2",    64'(rf_rs2),    64'(in_rs2));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_op1",   64'(out_op1),   64'(m_op1));
    chk("out_op2",   64'(out_op2),   64'(m_op2));
    chk("out_rd",    64'(out_rd),    64'(m_rd));
    chk("out_rd_we", 64'(out_rd_we), 64'(m_rd_we));
    chk("out_tag",   64'(out_tag),   64'(m_tag));
    chk("pend",      64'(dut.pend_q), 64'(pend_vec()));
    if (acc) begin
      m_valid = 1'b1;
      m_op1   = operand(in_rs1);
      m_op2   = operand(in_rs2);
      m_rd    = in_rd;
      m_rd_we = in_rd_we && in_rd != 5'd0;
      m_tag   = in_tag;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (wb_we && wb_rd != 5'd0) m_pend[wb_rd] = 1'b0;
    if (acc && in_rd_we && in_rd != 5'd0) m_pend[in_rd] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_in(bit v, logic [4:0] r1, logic [4:0] r2, logic [4:0] rd, bit we,
                          logic [TAG_W-1:0] tag);
    in_valid = v; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_rd_we = we; in_tag = tag;
  endtask

  task automatic drive_wb(bit we, logic [4:0] rd, logic [XLEN-1:0] wd);
    wb_we = we; wb_rd = rd; wb_wd = wd;
  endtask

  task automatic idle();
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, '0);
    drive_wb(1'b0, 5'd0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset op1",       64'(out_op1),   64'd0);
    chk("reset in_ready",  64'(in_ready),  64'd1);
    chk("reset pend",      64'(dut.pend_q), 64'd0);

    // Plain read
    drive_in(1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 32'hA1);
    step();
    chk("first op1", 64'(out_op1), 64'h11);
    chk("first op2", 64'(out_op2), 64'h22);
    chk("first valid", 64'(out_valid), 64'd1);

    // RAW on x5 released by writeback
    drive_in(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 32'hA2);
    step();
    chk("pend5 set", 64'(dut.pend_q[5]), 64'd1);
    drive_in(1'b1, 5'd5, 5'd0, 5'd6, 1'b0, 32'hA3);
    step();
    chk("raw stall", 64'(in_ready), 64'd0);
    step();
    drive_wb(1'b1, 5'd5, 32'hDEAD);
    step();
    drive_wb(1'b0, 5'd0, '0);
    if (!BYP) step();
    chk("raw op1", 64'(out_op1), 64'hDEAD);
    chk("raw tag", 64'(out_tag), 64'hA3);
    idle();
    step();

    // x0 reads and x0 destination
    force_ones = 1'b1;
    drive_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 32'hA4);
    drive_wb(1'b1, 5'd0, 32'h1234);
    step();
    chk("x0 op1", 64'(out_op1), 64'd0);
    chk("x0 op2", 64'(out_op2), 64'd0);
    chk("x0 rd_we", 64'(out_rd_we), 64'd0);
    chk("x0 pend", 64'(dut.pend_q), 64'd0);
    force_ones = 1'b0;
    idle();

    // Back-pressure, then 1/cycle drain
    drive_in(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 32'hB0);
    step();
    out_ready = 1'b0;
    drive_in(1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 32'hB1);
    repeat (3) step();
    chk("hold tag", 64'(out_tag), 64'hB0);
    chk("hold ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    chk("release tag", 64'(out_tag), 64'hB1);
    drive_in(1'b1, 5'd4, 5'd3, 5'd0, 1'b0, 32'hB2);
    step();
    drive_in(1'b1, 5'd2, 5'd1, 5'd0, 1'b0, 32'hB3);
    step();
    chk("b2b tag", 64'(out_tag), 64'hB3);
    idle();

    // WAW on x7 with same-cycle clear
    drive_in(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 32'hC0);
    step();
    drive_in(1'b1, 5'd3, 5'd4, 5'd7, 1'b1, 32'hC1);
    drive_wb(1'b1, 5'd7, 32'h77);
    step();
    drive_wb(1'b0, 5'd0, '0);
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, '0);
    if (!BYP) drive_in(1'b1, 5'd3, 5'd4, 5'd7, 1'b1, 32'hC1);
    step();
    chk("waw pend7", 64'(dut.pend_q[7]), 64'd1);
    chk("waw tag", 64'(out_tag), 64'hC1);
    drive_in(1'b1, 5'd1, 5'd7, 5'd0, 1'b0, 32'hC2);
    step();
    chk("rs2 stall", 64'(in_ready), 64'd0);
    drive_wb(1'b1, 5'd7, 32'h777);
    step();
    drive_wb(1'b0, 5'd0, '0);
    step();
    idle();
    step();

    // Reset with an entry held and x9 pending
    drive_in(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 32'hD0);
    step();
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async valid", 64'(out_valid), 64'd0);
    chk("async pend",  64'(dut.pend_q), 64'd0);
    chk("async tag",   64'(out_tag), 64'd0);
    model_reset();
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Mixed traffic over a small register window
    for (int i = 0; i < 200; i++) begin
      drive_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 32'($urandom));
      drive_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    idle();
    out_ready = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
